// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the unified-memory arbiter.
//   state_t    - arbiter FSM states
//   PORT_I/D   - owner encoding for the latched winner
//   mem_lat_ok - legality check for the memory read latency parameter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  function automatic bit mem_lat_ok(input int unsigned lat);
    return lat >= 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_select.sv
// arb_select: priority decision and fetch-starvation streak counter.
// Ports:
//   clk_i, reset_i - clock, synchronous active-high reset
//   i_req_i        - fetch request pending
//   d_req_i        - data request pending
//   grant_i        - strobe: a grant is being taken this cycle
//   grant_d_o      - 1 = data wins, 0 = fetch wins (valid when a request exists)
//   streak_o       - consecutive data grants taken while a fetch waited
module arb_select #(
  parameter  int unsigned MAX_DATA_STREAK = 4,
  localparam int unsigned SW              = $clog2(MAX_DATA_STREAK + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          i_req_i,
  input  logic          d_req_i,
  input  logic          grant_i,
  output logic          grant_d_o,
  output logic [SW-1:0] streak_o
);

  localparam logic [SW-1:0] MAX_S = SW'(MAX_DATA_STREAK);

  logic [SW-1:0] streak_q, streak_d;

  // Data wins unless a fetch has already waited out the full streak.
  assign grant_d_o = d_req_i && !(i_req_i && (streak_q == MAX_S));
  assign streak_o  = streak_q;

  always_comb begin
    streak_d = streak_q;
    if (grant_i) begin
      if (grant_d_o && i_req_i) begin
        streak_d = (streak_q == MAX_S) ? MAX_S : streak_q + SW'(1);
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction-fetch and load/store accesses onto a
// single-port memory with fixed read latency. One access in flight at a time.
// Ports:
//   clk_i, reset_i         - clock, synchronous active-high reset
//   i_req/i_addr           - fetch request; i_done pulse with i_rdata
//   d_req/d_we/d_be/d_addr/d_wdata - data request; d_done pulse with d_rdata
//   mem_en/we/be/addr/wdata - memory strobe and latched access fields
//   mem_rdata              - memory read data, valid MEM_LAT cycles after mem_en
//   busy_o                 - high whenever the FSM is not idle
// All outputs are registered.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MEM_LAT         = 2,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_done,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy_o
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned CW   = $clog2(MEM_LAT + 1);
  localparam int unsigned SW   = $clog2(MAX_DATA_STREAK + 1);

  if (!mem_lat_ok(MEM_LAT)) begin : g_lat_chk
    $error("mem_arbiter: MEM_LAT must be at least 1");
  end

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              owner_q;
  logic              mem_en_q, mem_we_q, busy_q, i_done_q, d_done_q;
  logic [BE_W-1:0]   mem_be_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, i_rdata_q, d_rdata_q;

  logic          grant, grant_d, capture;
  logic [SW-1:0] streak;

  assign grant   = (state_q == IDLE) && (i_req || d_req);
  assign capture = (state_q == WAIT) && (cnt_q == CW'(1));

  arb_select #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_sel (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .i_req_i  (i_req),
    .d_req_i  (d_req),
    .grant_i  (grant),
    .grant_d_o(grant_d),
    .streak_o (streak)
  );

  a_streak_sat: assert property (@(posedge clk_i) disable iff (reset_i)
    streak <= SW'(MAX_DATA_STREAK));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:   if (i_req || d_req) state_d = ACCESS;
      ACCESS: begin
        state_d = WAIT;
        cnt_d   = CW'(MEM_LAT);
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe/done/busy flops are loaded from the next state so they line up
  // with the state they describe while still coming straight from flops.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= PORT_I;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mem_en_q <= (state_d == ACCESS);
      busy_q   <= (state_d != IDLE);
      i_done_q <= (state_d == DONE) && (owner_q == PORT_I);
      d_done_q <= (state_d == DONE) && (owner_q == PORT_D);
      if (grant) begin
        if (grant_d) begin
          owner_q     <= PORT_D;
          mem_we_q    <= d_we;
          mem_be_q    <= d_be;
          mem_addr_q  <= d_addr;
          mem_wdata_q <= d_wdata;
        end else begin
          owner_q     <= PORT_I;
          mem_we_q    <= 1'b0;
          mem_be_q    <= '1;
          mem_addr_q  <= i_addr;
          mem_wdata_q <= '0;
        end
      end
      if (capture) begin
        if (owner_q == PORT_I) begin
          i_rdata_q <= mem_rdata;
        end else if (!mem_we_q) begin
          d_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign i_done    = i_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_done    = d_done_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;

  // MEM_LAT=2 instance
  logic        i_done, d_done, mem_en, mem_we, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  // MEM_LAT=1 instance
  logic        i_done1, d_done1, mem_en1, mem_we1, busy1;
  logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [3:0]  mem_be1;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_DATA_STREAK(4)) dut (
    .clk_i(clk), .reset_i(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy_o(busy));

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_DATA_STREAK(4)) dut1 (
    .clk_i(clk), .reset_i(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done1), .i_rdata(i_rdata1),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_be(mem_be1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy_o(busy1));

  // Memory contents; data is only valid exactly MEM_LAT cycles after mem_en.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h40) return 32'h2008000A;
    return {a[15:0], ~a[15:0]};
  endfunction

  logic [32:0] p1 = '0, p2 = '0, q1 = '0;
  always @(posedge clk) begin
    p1 <= {mem_en, mem_f(mem_addr)};
    p2 <= p1;
    q1 <= {mem_en1, mem_f(mem_addr1)};
  end
  assign mem_rdata  = p2[32] ? p2[31:0] : 32'hDEADBEEF;
  assign mem_rdata1 = q1[32] ? q1[31:0] : 32'hDEADBEEF;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];
  vec_t v;
  logic [31:0] last_d;
  int d_at, i_at, cnt;
  logic [7:0] got[12];
  string exp_s;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_0040, 32'h0,         32'h2008_000A};
    vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0,         32'h0100_FEFF};
    vecs[2] = '{1'b1, 1'b1, 4'h1, 32'h0000_1000, 32'h0000_00FF, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 4'hF, 32'h0000_0044, 32'h0,         32'h0044_FFBB};
    vecs[4] = '{1'b1, 1'b1, 4'hF, 32'h0000_2000, 32'hCAFE_F00D, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 4'h3, 32'h0000_3FFC, 32'h0,         32'h3FFC_C003};

    // Reset values
    reset = 1'b1;
    tick(); tick();
    chk("rst i_done", i_done, 0);   chk("rst d_done", d_done, 0);
    chk("rst mem_en", mem_en, 0);   chk("rst mem_we", mem_we, 0);
    chk("rst busy", busy, 0);       chk("rst mem_be", mem_be, 0);
    chk("rst mem_addr", mem_addr, 0); chk("rst mem_wdata", mem_wdata, 0);
    chk("rst i_rdata", i_rdata, 0); chk("rst d_rdata", d_rdata, 0);
    reset = 1'b0;
    last_d = '0;

    // Table: single transactions on both latency builds
    for (int n = 0; n < 6; n++) begin
      v = vecs[n];
      if (v.is_d) begin
        d_req = 1'b1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
        i_req = 1'b1; i_addr = v.addr;
      end
      for (int k = 1; k <= 5; k++) begin
        tick();
        chk($sformatf("v%0d c%0d mem_en", n, k), mem_en, k == 1);
        chk($sformatf("v%0d c%0d busy", n, k), busy, k <= 4);
        chk($sformatf("v%0d c%0d i_done", n, k), i_done, !v.is_d && k == 4);
        chk($sformatf("v%0d c%0d d_done", n, k), d_done, v.is_d && k == 4);
        chk($sformatf("v%0d c%0d i_done1", n, k), i_done1, !v.is_d && k == 3);
        chk($sformatf("v%0d c%0d d_done1", n, k), d_done1, v.is_d && k == 3);
        if (k == 1 || k == 3) begin
          chk($sformatf("v%0d c%0d mem_addr", n, k), mem_addr, v.addr);
          chk($sformatf("v%0d c%0d mem_we", n, k), mem_we, v.we);
          if (v.is_d) chk($sformatf("v%0d c%0d mem_be", n, k), mem_be, v.be);
          if (v.we) chk($sformatf("v%0d c%0d mem_wdata", n, k), mem_wdata, v.wdata);
        end
        if (k == 3) begin
          if (!v.is_d) chk($sformatf("v%0d i_rdata1", n), i_rdata1, v.exp_rdata);
          else chk($sformatf("v%0d d_rdata1", n), d_rdata1, v.we ? last_d : v.exp_rdata);
        end
        if (k == 4) begin
          if (!v.is_d) chk($sformatf("v%0d i_rdata", n), i_rdata, v.exp_rdata);
          else chk($sformatf("v%0d d_rdata", n), d_rdata, v.we ? last_d : v.exp_rdata);
          i_req = 1'b0; d_req = 1'b0;
        end
      end
      if (v.is_d && !v.we) last_d = v.exp_rdata;
    end

    // Simultaneous requests: data first, fetch sampled in the following IDLE
    reset = 1'b1; tick(); reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h100;
    d_at = -1; i_at = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (d_done) begin
        if (d_at < 0) d_at = k;
        d_req = 1'b0;
      end
      if (i_done) begin
        if (i_at < 0) i_at = k;
        i_req = 1'b0;
      end
      if (k == 6) begin
        chk("sim fetch mem_en", mem_en, 1);
        chk("sim fetch mem_addr", mem_addr, 32'h40);
      end
    end
    chk("sim d_done cycle", d_at, 4);
    chk("sim i_done cycle", i_at, 9);
    chk("sim d_rdata", d_rdata, 32'h0100_FEFF);
    chk("sim i_rdata", i_rdata, 32'h2008_000A);

    // Starvation guard: both requests held continuously
    reset = 1'b1; tick(); reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h100;
    cnt = 0;
    for (int j = 0; j < 12; j++) got[j] = "-";
    for (int k = 0; k < 80 && cnt < 12; k++) begin
      tick();
      if (d_done && cnt < 12) begin got[cnt] = "D"; cnt++; end
      if (i_done && cnt < 12) begin got[cnt] = "I"; cnt++; end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("starve completions", cnt, 12);
    exp_s = "DDDDIDDDDIDD";
    for (int j = 0; j < 12; j++) begin
      chk($sformatf("starve order %0d", j), got[j], exp_s[j]);
    end

    // Reset while waiting on memory: access abandoned, no done, late data ignored
    tick(); tick(); tick(); tick(); tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h44;
    tick();
    chk("rstw mem_en", mem_en, 1);
    tick();
    chk("rstw in wait busy", busy, 1);
    reset = 1'b1; i_req = 1'b0;
    tick();
    chk("rstw busy", busy, 0);    chk("rstw busy1", busy1, 0);
    chk("rstw i_done", i_done, 0); chk("rstw i_done1", i_done1, 0);
    reset = 1'b0;
    for (int k = 4; k <= 9; k++) begin
      tick();
      chk($sformatf("rstw c%0d i_done", k), i_done, 0);
      chk($sformatf("rstw c%0d i_done1", k), i_done1, 0);
      chk($sformatf("rstw c%0d i_rdata", k), i_rdata, 0);
      chk($sformatf("rstw c%0d i_rdata1", k), i_rdata1, 0);
      chk($sformatf("rstw c%0d busy", k), busy, 0);
    end

    // Request dropped one cycle after issue is still completed
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h3FFC;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) d_req = 1'b0;
      chk($sformatf("drop c%0d d_done", k), d_done, k == 4);
      chk($sformatf("drop c%0d busy", k), busy, k <= 4);
    end
    chk("drop d_rdata", d_rdata, 32'h3FFC_C003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
